// File: rtl/sa_pkg.sv
// Shared definitions for the systolic MAC array and its skew feeder:
// feeder state encoding, default array dimensions and the flush-length helper.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feed_state_e;

    localparam int SA_WIDTH = 8;
    localparam int SA_ACC   = 32;
    localparam int SA_N     = 2;

    // Zero cycles needed after the last beat so the far corner PE sees its final product.
    function automatic int flush_len(input int n);
        return (n > 1) ? (2 * n - 2) : 0;
    endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Operand stream into the skew feeder: one A column and one B row per beat,
// transferred on in_valid & in_ready.
interface sa_skew_feeder_if
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int WIDTH = SA_WIDTH
);

    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0][WIDTH-1:0] a_vec;
    logic [N-1:0][WIDTH-1:0] b_vec;

    modport master (output in_valid, a_vec, b_vec, input in_ready);
    modport slave  (input in_valid, a_vec, b_vec, output in_ready);

endinterface

// File: rtl/sa_skew_line.sv
// Enable-gated shift register of DEPTH stages with asynchronous active-high clear;
// q is the oldest stage.
module sa_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int s = 1; s < DEPTH; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Diagonal-skew feeder for the NxN systolic MAC array: streams K beats, flushes zeros,
// drives the array enable and pulses done. Optional stall counter: SA_FEED_STALL_CNT_EN.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int N     = SA_N,
    parameter int K_MAX = 255,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    sa_skew_feeder_if.slave         in_if,
    output logic                    sa_en,
    output logic [N-1:0][WIDTH-1:0] sa_a,
    output logic [N-1:0][WIDTH-1:0] sa_b,
    output logic                    busy,
    output logic                    done
`ifdef SA_FEED_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int FLUSH_CYCLES = flush_len(N);
    localparam int FLUSH_LOAD   = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam int FW           = $clog2(FLUSH_CYCLES + 1) + 1;

    feed_state_e   state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sa_en_q, sa_en_d;

    logic fire;
    logic advance;

    assign fire    = in_if.in_valid & in_ready_q;
    assign advance = fire | (state_q == FLUSH);

    always_comb begin
        state_d    = state_q;
        k_len_d    = k_len_q;
        beat_d     = beat_q;
        flush_d    = flush_q;
        done_d     = (state_q == DONE);
        sa_en_d    = advance;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_len_d = k_len;
                        beat_d  = '0;
                        state_d = STREAM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                if (fire) begin
                    if (beat_q == k_len_q - KW'(1)) begin
                        beat_d = '0;
                        if (N == 1) begin
                            state_d = DONE;
                        end else begin
                            flush_d = FW'(FLUSH_LOAD);
                            state_d = FLUSH;
                        end
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_q == '0) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and status outputs are registered from the next state.
        in_ready_d = (state_d == STREAM);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_len_q    <= '0;
            beat_q     <= '0;
            flush_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sa_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_len_q    <= k_len_d;
            beat_q     <= beat_d;
            flush_q    <= flush_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sa_en_q    <= sa_en_d;
        end
    end

    // Lane i is delayed i beats; a stalled beat shifts nothing, so no bubble enters the array.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] a_lane;
        logic [WIDTH-1:0] b_lane;

        assign a_lane = fire ? in_if.a_vec[i] : '0;
        assign b_lane = fire ? in_if.b_vec[i] : '0;

        sa_skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_line_a (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (a_lane),
            .q   (sa_a[i])
        );

        sa_skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_line_b (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (b_lane),
            .q   (sa_b[i])
        );
    end

`ifdef SA_FEED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && !in_if.in_valid && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign in_if.in_ready = in_ready_q;
    assign sa_en          = sa_en_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: directed jobs from the test plan plus random jobs,
// checked cycle by cycle against a skew/flush model and an ideal NxN array dot-product model.
module tb_sa_skew_feeder;
    import sa_pkg::*;

    localparam int N     = 2;
    localparam int WIDTH = 8;
    localparam int K_MAX = 255;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int F     = 2 * N - 2;
    localparam int MAXC  = 400;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [KW-1:0]           k_len = '0;
    logic                    sa_en;
    logic                    busy;
    logic                    done;
    logic [N-1:0][WIDTH-1:0] sa_a;
    logic [N-1:0][WIDTH-1:0] sa_b;
`ifdef SA_FEED_STALL_CNT_EN
    logic [31:0]             stall_cycles;
`endif

    sa_skew_feeder_if #(.N(N), .WIDTH(WIDTH)) in_if ();

    sa_skew_feeder #(.WIDTH(WIDTH), .N(N), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .in_if        (in_if.slave),
        .sa_en        (sa_en),
        .sa_a         (sa_a),
        .sa_b         (sa_b),
        .busy         (busy),
        .done         (done)
`ifdef SA_FEED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] beat_a [MAXC][N];
    logic [WIDTH-1:0] beat_b [MAXC][N];
    int               gap    [MAXC];
    logic [WIDTH-1:0] seq_a  [MAXC][N];
    logic [WIDTH-1:0] seq_b  [MAXC][N];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [KW-1:0] kl, input logic v,
                                 input logic [N-1:0][WIDTH-1:0] a, input logic [N-1:0][WIDTH-1:0] b);
        start          = s;
        k_len          = kl;
        in_if.in_valid = v;
        in_if.a_vec    = a;
        in_if.b_vec    = b;
    endtask

    function automatic logic [N-1:0][WIDTH-1:0] rand_vec();
        logic [N-1:0][WIDTH-1:0] r;
        for (int i = 0; i < N; i++) r[i] = WIDTH'($urandom);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_sa_en"}, 32'(sa_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_if.in_ready), 32'd0);
        checkOutput({tag, "_sa_a"}, 32'(sa_a), 32'd0);
        checkOutput({tag, "_sa_b"}, 32'(sa_b), 32'd0);
    endtask

    // One job: cycle 0 issues start, beats follow gap[] stalls. Expected timing comes from
    // the job's own shape; lane values from "lane i at enabled step t carries beat t-i".
    task automatic run_job(input int k, input bit end_at_done, input bit prev_done,
                           input bit spurious, input int abort_at);
        int  s_tot, len, exp_done, last, stp, bi, gcnt;
        bit  adv, prev_adv;
        logic [N-1:0][WIDTH-1:0] va, vb;
        logic [WIDTH-1:0] ev;

        s_tot = 0;
        for (int b = 0; b < k; b++) s_tot += gap[b];
        len      = k + s_tot;
        exp_done = (k == 0) ? 2 : len + F + 2;
        last     = end_at_done ? exp_done : exp_done + 2;
        stp      = 0;
        bi       = 0;
        gcnt     = (k > 0) ? gap[0] : 0;
        prev_adv = 1'b0;

        for (int c = 0; c < last; c++) begin
            checkOutput("sa_en", 32'(sa_en), 32'(prev_adv));
            checkOutput("done", 32'(done), (c == 0) ? 32'(prev_done) : 32'(c == exp_done));
            checkOutput("busy", 32'(busy), 32'(c >= 1 && c < exp_done));
            checkOutput("in_ready", 32'(in_if.in_ready), 32'(c >= 1 && c <= len));
            if (prev_adv) begin
                for (int i = 0; i < N; i++) begin
                    seq_a[stp][i] = sa_a[i];
                    seq_b[stp][i] = sa_b[i];
                    ev = (stp - i >= 0 && stp - i < k) ? beat_a[stp - i][i] : '0;
                    checkOutput($sformatf("sa_a[%0d]@step%0d", i, stp), 32'(sa_a[i]), 32'(ev));
                    ev = (stp - i >= 0 && stp - i < k) ? beat_b[stp - i][i] : '0;
                    checkOutput($sformatf("sa_b[%0d]@step%0d", i, stp), 32'(sa_b[i]), 32'(ev));
                end
                stp++;
            end
`ifdef SA_FEED_STALL_CNT_EN
            if (c == 1) checkOutput("stall_clear", stall_cycles, 32'd0);
            if (c == exp_done - 1) checkOutput("stall_count", stall_cycles, 32'(s_tot));
`endif
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_all_zero("abort");
                step();
                step();
                rst = 1'b0;
                for (int w = 0; w < 4; w++) begin
                    step();
                    checkOutput("abort_no_done", 32'(done), 32'd0);
                    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
                end
                return;
            end

            adv = 1'b0;
            if (c >= 1 && c <= len) begin
                if (gcnt > 0) begin
                    gcnt--;
                    applyStimulus(1'b0, KW'($urandom), 1'b0, rand_vec(), rand_vec());
                end else begin
                    for (int i = 0; i < N; i++) begin
                        va[i] = beat_a[bi][i];
                        vb[i] = beat_b[bi][i];
                    end
                    applyStimulus(1'b0, KW'($urandom), 1'b1, va, vb);
                    bi++;
                    gcnt = (bi < k) ? gap[bi] : 0;
                    adv  = 1'b1;
                end
            end else begin
                applyStimulus(1'b0, KW'($urandom), 1'($urandom), rand_vec(), rand_vec());
                if (k > 0 && c > len && c <= len + F) adv = 1'b1;
            end
            if (c == 0) begin
                start = 1'b1;
                k_len = KW'(k);
            end else if (spurious && (c == 1 || c == exp_done - 1)) begin
                start = 1'b1;
                k_len = KW'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            prev_adv = adv;
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0);

        // Ideal array: PE(i,j) multiplies sa_a[i] delayed j steps by sa_b[j] delayed i steps.
        if (k > 0 && !end_at_done) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    int acc_obs, acc_exp, xa, xb;
                    acc_obs = 0;
                    acc_exp = 0;
                    for (int t = 0; t < k + F; t++) begin
                        if (t - j >= 0 && t - i >= 0) begin
                            xa = int'($signed(seq_a[t - j][i]));
                            xb = int'($signed(seq_b[t - i][j]));
                            acc_obs += xa * xb;
                        end
                    end
                    for (int b = 0; b < k; b++) begin
                        xa = int'($signed(beat_a[b][i]));
                        xb = int'($signed(beat_b[b][j]));
                        acc_exp += xa * xb;
                    end
                    checkOutput($sformatf("acc[%0d][%0d]", i, j), 32'(acc_obs), 32'(acc_exp));
                end
            end
        end
    endtask

    task automatic load_plan_job();
        beat_a[0][0] = 8'd1; beat_a[0][1] = 8'd3;
        beat_a[1][0] = 8'd2; beat_a[1][1] = 8'd4;
        beat_b[0][0] = 8'd5; beat_b[0][1] = 8'd6;
        beat_b[1][0] = 8'd7; beat_b[1][1] = 8'd8;
        gap[0] = 0;
        gap[1] = 0;
    endtask

    task automatic load_random_job(input int k);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i < N; i++) begin
                beat_a[b][i] = WIDTH'($urandom);
                beat_b[b][i] = WIDTH'($urandom);
            end
            gap[b] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  k;
        bit  chain;
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
`ifdef SA_FEED_STALL_CNT_EN
        checkOutput("reset_stall", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        step();

        $display("[TB] plan job, no stalls");
        load_plan_job();
        run_job(2, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] plan job, two stall cycles between beats");
        gap[1] = 2;
        run_job(2, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] zero-length job");
        run_job(0, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] reset during flush, then fresh job");
        load_plan_job();
        run_job(2, 1'b0, 1'b0, 1'b0, 3);
        run_job(2, 1'b0, 1'b0, 1'b0, -1);

        $display("[TB] start during stream and in done ignored, start with done accepted");
        run_job(2, 1'b1, 1'b0, 1'b1, -1);
        load_random_job(5);
        run_job(5, 1'b0, 1'b1, 1'b0, -1);

        $display("[TB] random jobs");
        chain = 1'b0;
        for (int r = 0; r < 14; r++) begin
            bit nxt;
            k   = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 10));
            nxt = 1'($urandom);
            load_random_job(k);
            run_job(k, nxt, chain, 1'($urandom), -1);
            chain = nxt;
        end
        k = 3;
        load_random_job(k);
        run_job(k, 1'b0, chain, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Upstream stage of the 2D systolic MAC array (NxN PEs, signed WIDTH-bit operands, ACC-bit accumulators, single global enable).
- Accepts one A-column vector and one B-row vector per beat over a valid/ready stream, for K beats.
- Applies diagonal skew: row/column lane i is delayed i beats. Then injects zero-flush cycles so every PE completes its dot product, and drives the array enable throughout.
- Pulses done when all accumulators hold final results.

Parameters:
- WIDTH, 8, signed operand width
- N, 2, array dimension (lanes per operand vector)
- K_MAX, 255, maximum beats per job
- KW, $clog2(K_MAX+1), width of k_len

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job start request, sampled in IDLE only
- k_len  in  KW  beats in job, latched on accepted start
- in_valid  in  1  a_vec/b_vec valid
- in_ready  out  1  feeder accepts beat
- a_vec  in  N x WIDTH signed  A column k, lane i = A[i][k]
- b_vec  in  N x WIDTH signed  B row k, lane j = B[k][j]
- sa_en  out  1  array enable
- sa_a  out  N x WIDTH signed  skewed row operands to array a_in
- sa_b  out  N x WIDTH signed  skewed column operands to array b_in
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: state=IDLE; all skew registers, sa_a, sa_b = 0; sa_en, done, in_ready, busy = 0; counters = 0.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE: in_ready=0; in_valid ignored.
    - start & k_len!=0: latch k_len, go to STREAM.
    - start & k_len==0: go to DONE; sa_en never asserts.
  - STREAM: in_ready=1; fire = in_valid & in_ready.
    - Count fires. On the k_len-th fire, go to FLUSH, or to DONE if N==1.
  - FLUSH: lasts exactly 2N-2 cycles, counted down. Then go to DONE.
  - DONE: exactly 1 cycle, then IDLE. start is ignored in DONE.
- advance = fire (STREAM) | 1 (FLUSH). Lane input = fire ? vector : 0.
- Skew lines: lane i has i+1 registers, all shifting only on advance. sa_a[i]/sa_b[i] are the last stage.
- sa_en is advance registered one cycle, so data and enable are always aligned.
- Stall: in STREAM with in_valid=0, skew registers hold and sa_en=0 in the following cycle. The array freezes with no bubble corruption.
- Cycle counts:
  - sa_en is high for exactly k_len + 2N-2 cycles per job.
  - The last sa_en cycle coincides with the DONE state.
  - done is registered (state==DONE), i.e. it is high in the first IDLE cycle after DONE.
- start while busy: ignored, no queuing. start and the done pulse may coincide; that start is accepted (state is IDLE).
- rst mid-job: immediate abort to reset values; no done pulse.
- No arithmetic: operands pass bit-exact; the zero flush value is signed 0.

Optional Feature:
- Macro SA_FEED_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0]. It counts STREAM cycles with in_valid=0, clears on accepted start and on rst, and saturates at all-ones.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sa_pkg holds:
  - the feeder state enum (IDLE/STREAM/FLUSH/DONE);
  - default WIDTH/ACC/N constants shared with the array;
  - the function computing flush length 2N-2.
- Sub-module sa_skew_line, parameters WIDTH and DEPTH: enable-gated shift register with async active-high clear. The feeder instantiates 2N of them (DEPTH = i+1).

Test Plan:
- N=2, k_len=2, beats a=(1,3),(2,4), b=(5,6),(7,8), in_valid constant, start at cycle 0 -> sa_en high in cycles 2-5; sa_a[0]=1,2,0,0; sa_a[1]=0,3,4,0; sa_b[0]=5,7,0,0; sa_b[1]=0,6,8,0; done high cycle 6 only. With the array attached, acc_out[0][0]=19.
- Same job with in_valid low for 2 cycles between beats -> sa_en low for exactly 2 cycles; skewed value sequence on sa_en cycles identical to the previous test; done at cycle 8.
- k_len=0 start -> in_ready never high, sa_en never high, busy high 1 cycle, done high cycle 2.
- rst asserted during FLUSH -> all outputs 0 in the same cycle; no done; a fresh job after release matches the first test.
- start pulsed during STREAM and together with done -> the first is ignored; the second launches a new job. in_valid during IDLE is never accepted.
- With SA_FEED_STALL_CNT_EN, the second test gives stall_cycles=2; a new start clears it to 0.
